exe_alu_pipe: RTL and testbench
===============================

Name: exe_alu_pipe

Overview:
- Execute-stage ALU of the Y86 pipeline: selects operands from icode/ifun, computes valE, and holds the condition codes (ZF/SF/OF).
- Registered stage with valid/ready handshake toward Memory, so the stage can stall and be flushed.
- Fully width-parametrised.
- Optional iterative multi-cycle multiply (ifun MULQ).

Parameters:
- DATA_WIDTH, 64, width of valA/valB/valC/valE; must be ≥8 and even.
- MUL_STEP_BITS, 2, multiplier bits retired per cycle; must divide DATA_WIDTH; used only with ALU_MUL_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  squash accepted/in-flight op (mispredict)
- in_valid_i  in  1  E-register holds a valid instruction
- in_ready_o  out  1  stage can accept this cycle
- E_icode_i  in  4  instruction code
- E_ifun_i  in  4  function code
- E_valC_i  in  DATA_WIDTH  immediate/displacement
- E_valA_i  in  DATA_WIDTH  operand A
- E_valB_i  in  DATA_WIDTH  operand B
- set_cc_i  in  1  CC write permitted (low when a later stage has an exception)
- out_valid_o  out  1  valE_o valid
- out_ready_i  in  1  Memory stage consumes result
- valE_o  out  DATA_WIDTH  ALU result
- cc_o  out  3  {ZF,SF,OF} architectural CC register
- busy_o  out  1  multiply in progress
- bad_fun_o  out  1  one-cycle pulse: unsupported ALU function accepted

Behaviour:
- Reset (rst_i high at clk edge): out_valid_o=0, valE_o=0, cc_o=3'b100 (ZF=1), busy_o=0, bad_fun_o=0, multiply state cleared. Reset mid-multiply aborts it.
- Accept when in_valid_i && in_ready_o.
- in_ready_o = !busy_o && (!out_valid_o || out_ready_i).
- Result = aluA fun aluB. Function codes: ADDQ=0, SUBQ=1 (aluA-aluB), ANDQ=2, XORQ=3, MULQ=4.
- Operand mapping, as (aluA, aluB, fun):
  - CXX: valA, 0, ADD.
  - IXX ifun0 (irmovq): 0, valC, ADD.
  - IXX ifun1..5: valB, valC, ifun-1.
  - OPQ: valB, valA, ifun.
  - RMMOVQ: valB, valC, ADD.
  - MRMOVQ: valA, valC, ADD.
  - CALL, PUSHQ: valB, 8, SUB.
  - RET, POPQ: valB, 8, ADD.
  - JXX, HALT, NOP, other: 0, 0, ADD, giving valE=0.
- Arithmetic is modulo 2^DATA_WIDTH. Immediate 8 is zero-extended to DATA_WIDTH.
- Latency: single-cycle functions set out_valid_o on the edge after accept. The result is held stable while out_valid_o && !out_ready_i.
- out_valid_o clears on consume unless a new op is accepted in the same cycle (back-to-back throughput 1/cycle).
- CC update, in the accept cycle's edge:
  - Only for OPQ, or IXX with ifun≠0, and only when set_cc_i=1 and flush_i=0.
  - ZF = result==0; SF = result[MSB].
  - OF for ADD: operands same sign and result sign differs.
  - OF for SUB: operand signs differ and result sign differs from aluA.
  - OF for AND/XOR: 0.
- flush_i:
  - Takes priority over accept; the op presented that cycle is dropped with no CC change.
  - Clears out_valid_o and aborts a running multiply (busy_o→0 next edge).
- Unsupported fun (≥5, or 4 without ALU_MUL_EN): valE=0, CC unchanged, bad_fun_o pulses for 1 cycle with out_valid_o.

Optional Feature:
- Macro ALU_MUL_EN.
- With ALU_MUL_EN:
  - MULQ is an iterative signed multiply. States: IDLE→MUL→DONE.
  - MUL retires MUL_STEP_BITS per cycle over DATA_WIDTH/MUL_STEP_BITS cycles (32 at defaults). busy_o=1 from the edge after accept through the last step.
  - valE = low DATA_WIDTH bits of the signed product. OF=1 iff the product does not fit signed DATA_WIDTH. ZF/SF as above.
  - out_valid_o asserts the edge after the final step.
- Without ALU_MUL_EN: fun 4 is unsupported (see above); busy_o tied 0; no multiplier logic.

Test Plan:
- OPQ SUB: valA=5, valB=3, set_cc=1 -> next cycle valE=0xFFFF_FFFF_FFFF_FFFE, cc={0,1,0}.
- OPQ ADD: valA=valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, cc={0,1,1}. Same op with set_cc=0 -> cc unchanged.
- PUSHQ with valB=0x100 followed back-to-back by POPQ with valB=0xF8 -> valE 0xF8 then 0x100 on consecutive cycles. cc unchanged.
- Backpressure: out_ready_i=0 for 3 cycles after an IXX ifun0 op with valC=0x1234 -> valE held at 0x1234, in_ready_o=0. A new op is accepted the cycle out_ready_i rises.
- flush_i asserted with OPQ XOR (valA=valB=7) -> no out_valid_o, cc unchanged. rst_i mid-stream -> all outputs return to reset values next edge.
- ALU_MUL_EN: MULQ valA=-3, valB=7 -> busy_o for 32 cycles, then valE=-21, cc={0,1,0}. valA=valB=2^32 -> valE=0, cc={1,0,1}. Without the macro -> valE=0, bad_fun_o pulse.

Source files
------------

// File: rtl/exe_alu_pipe_if.sv
// Handshake bundle between the Y86 E register, the execute ALU stage and the Memory stage.
// Parametrised by DATA_WIDTH; "master" drives operands and consumes results, "slave" is the ALU.
interface exe_alu_pipe_if #(parameter int DATA_WIDTH = 64);
  // valid/ready: a transfer occurs on a rising clock edge where valid and ready are both high;
  // the producer holds valid and its payload stable until then, and ready never depends on valid.
  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [3:0]            E_icode_i;
  logic [3:0]            E_ifun_i;
  logic [DATA_WIDTH-1:0] E_valC_i;
  logic [DATA_WIDTH-1:0] E_valA_i;
  logic [DATA_WIDTH-1:0] E_valB_i;
  logic                  set_cc_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] valE_o;

  modport master (
    output flush_i, in_valid_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
           set_cc_i, out_ready_i,
    input  in_ready_o, out_valid_o, valE_o
  );

  modport slave (
    input  flush_i, in_valid_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
           set_cc_i, out_ready_i,
    output in_ready_o, out_valid_o, valE_o
  );
endinterface

// File: rtl/exe_alu_pipe.sv
// Y86 execute stage: operand select, ALU, CC register, registered valid/ready output.
// Define ALU_MUL_EN to add the iterative signed multiply (MULQ, fun 4).
module exe_alu_pipe #(
  parameter int DATA_WIDTH    = 64,
  parameter int MUL_STEP_BITS = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  exe_alu_pipe_if.slave  bus,
  output logic [2:0]     cc_o,
  output logic           busy_o,
  output logic           bad_fun_o,
  output logic [1:0]     state_o
);
  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [3:0] I_CXX = 4'h2, I_IXX = 4'h3, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ = 4'h6, I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_AND = 4'd2, F_XOR = 4'd3, F_MUL = 4'd4;
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] w_alu_a, w_alu_b, w_res, w_eight;
  logic [3:0]            w_fun;
  logic                  w_cc_op, w_of, w_bad, w_is_mul, w_accept;
  logic [DATA_WIDTH-1:0] r_valE;
  logic                  r_out_valid, r_bad;
  logic [2:0]            r_cc;
  logic [1:0]            r_state;

  assign w_eight        = DATA_WIDTH'(8);
  assign bus.in_ready_o = (r_state != S_MUL) && (!r_out_valid || bus.out_ready_i);
  assign w_accept       = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
  assign bus.out_valid_o = r_out_valid;
  assign bus.valE_o     = r_valE;
  assign cc_o           = r_cc;
  assign busy_o         = (r_state == S_MUL);
  assign bad_fun_o      = r_bad;
  assign state_o        = r_state;

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    w_fun   = F_ADD;
    w_cc_op = 1'b0;
    case (bus.E_icode_i)
      I_CXX: w_alu_a = bus.E_valA_i;
      I_IXX: begin
        w_alu_b = bus.E_valC_i;
        if (bus.E_ifun_i != 4'd0) begin
          w_alu_a = bus.E_valB_i;
          w_fun   = bus.E_ifun_i - 4'd1;
          w_cc_op = 1'b1;
        end
      end
      I_OPQ: begin
        w_alu_a = bus.E_valB_i;
        w_alu_b = bus.E_valA_i;
        w_fun   = bus.E_ifun_i;
        w_cc_op = 1'b1;
      end
      I_RMMOVQ: begin w_alu_a = bus.E_valB_i; w_alu_b = bus.E_valC_i; end
      I_MRMOVQ: begin w_alu_a = bus.E_valA_i; w_alu_b = bus.E_valC_i; end
      I_CALL, I_PUSHQ: begin w_alu_a = bus.E_valB_i; w_alu_b = w_eight; w_fun = F_SUB; end
      I_RET, I_POPQ:   begin w_alu_a = bus.E_valB_i; w_alu_b = w_eight; end
      default: ;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (w_fun)
      F_ADD: begin
        w_res = w_alu_a + w_alu_b;
        w_of  = (w_alu_a[MSB] == w_alu_b[MSB]) && (w_res[MSB] != w_alu_a[MSB]);
      end
      F_SUB: begin
        w_res = w_alu_a - w_alu_b;
        w_of  = (w_alu_a[MSB] != w_alu_b[MSB]) && (w_res[MSB] != w_alu_a[MSB]);
      end
      F_AND:   w_res = w_alu_a & w_alu_b;
      F_XOR:   w_res = w_alu_a ^ w_alu_b;
      default: ;
    endcase
  end

  assign w_bad    = (w_fun > F_MUL) || ((w_fun == F_MUL) && !MUL_EN);
  assign w_is_mul = MUL_EN && (w_fun == F_MUL);

`ifdef ALU_MUL_EN
  // Sign-magnitude shift-add: unsigned magnitudes, product negated at the end if signs differ.
  localparam int STEPS = DATA_WIDTH / MUL_STEP_BITS;
  localparam int CW    = $clog2(STEPS) + 1;
  logic [2*DATA_WIDTH-1:0] r_prod, r_mcand, w_prod_next, w_prod_signed;
  logic [DATA_WIDTH-1:0]   r_mplier, w_abs_a, w_abs_b;
  logic [CW-1:0]           r_cnt;
  logic                    r_neg, r_mul_cc, w_last, w_mul_of;

  assign w_abs_a = w_alu_a[MSB] ? -w_alu_a : w_alu_a;
  assign w_abs_b = w_alu_b[MSB] ? -w_alu_b : w_alu_b;
  assign w_last  = (r_cnt == CW'(STEPS - 1));

  always_comb begin
    w_prod_next = r_prod;
    for (int k = 0; k < MUL_STEP_BITS; k++)
      if (r_mplier[k]) w_prod_next = w_prod_next + (r_mcand << k);
    w_prod_signed = r_neg ? -w_prod_next : w_prod_next;
  end

  // Fits in signed DATA_WIDTH only if the upper half plus the result sign bit are all equal.
  assign w_mul_of = !((&w_prod_signed[2*DATA_WIDTH-1:MSB]) || (~|w_prod_signed[2*DATA_WIDTH-1:MSB]));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_valE      <= '0;
      r_cc        <= 3'b100;
      r_bad       <= 1'b0;
      r_state     <= S_IDLE;
`ifdef ALU_MUL_EN
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_mul_cc <= 1'b0;
`endif
    end else if (bus.flush_i) begin
      r_out_valid <= 1'b0;
      r_bad       <= 1'b0;
      r_state     <= S_IDLE;
    end else begin
      r_bad <= 1'b0;
      if (r_state == S_DONE) r_state <= S_IDLE;
      if (w_accept) begin
        if (w_is_mul) begin
          r_state     <= S_MUL;
          r_out_valid <= 1'b0;
`ifdef ALU_MUL_EN
          r_prod   <= '0;
          r_mcand  <= {{DATA_WIDTH{1'b0}}, w_abs_a};
          r_mplier <= w_abs_b;
          r_cnt    <= '0;
          r_neg    <= w_alu_a[MSB] ^ w_alu_b[MSB];
          r_mul_cc <= bus.set_cc_i;
`endif
        end else begin
          r_out_valid <= 1'b1;
          r_valE      <= w_bad ? '0 : w_res;
          r_bad       <= w_bad;
          if (w_cc_op && bus.set_cc_i && !w_bad)
            r_cc <= {(w_res == '0), w_res[MSB], w_of};
        end
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
`ifdef ALU_MUL_EN
      if (r_state == S_MUL) begin
        r_prod   <= w_prod_next;
        r_mcand  <= r_mcand << MUL_STEP_BITS;
        r_mplier <= r_mplier >> MUL_STEP_BITS;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_valE      <= w_prod_signed[MSB:0];
          if (r_mul_cc)
            r_cc <= {(w_prod_signed[MSB:0] == '0), w_prod_signed[MSB], w_mul_of};
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_exe_alu_pipe.sv
// Self-checking bench for exe_alu_pipe: per-feature tasks plus an output-side scoreboard on valE.
// Define ALU_MUL_EN to also exercise the multiplier.
module tb_exe_alu_pipe;
  localparam int W = 64;
  localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, IXX = 4'h3, OPQ = 4'h6, PUSHQ = 4'hA, POPQ = 4'hB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cc;
  logic       busy, bad;
  logic [1:0] state;
  logic [W-1:0] exp_q[$];
  logic [2:0] exp_cc;
  int vec_cnt = 0;
  int err_cnt = 0;

  exe_alu_pipe_if #(.DATA_WIDTH(W)) bus();

  exe_alu_pipe #(.DATA_WIDTH(W), .MUL_STEP_BITS(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave),
    .cc_o(cc), .busy_o(busy), .bad_fun_o(bad), .state_o(state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every consumed result must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL result_unexpected got=%h expected=<none>", bus.valE_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.valE_o !== e) begin
          err_cnt++;
          $display("FAIL result_valE got=%h expected=%h", bus.valE_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op and returns just after the edge that accepted it.
  task automatic send(input logic [3:0] icode, input logic [3:0] ifun, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] c, input logic scc,
                      input logic [W-1:0] exp, output int waited);
    bit done = 0;
    bus.E_icode_i = icode; bus.E_ifun_i = ifun;
    bus.E_valA_i = a; bus.E_valB_i = b; bus.E_valC_i = c;
    bus.set_cc_i = scc; bus.in_valid_i = 1'b1;
    waited = 0;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        exp_q.push_back(exp);
        tick();
        done = 1;
      end else waited++;
    end
    if (!done) begin
      err_cnt++; vec_cnt++;
      $display("FAIL send_timeout got=not_accepted expected=accepted");
      tick();
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL %s_drain got=%0d_pending expected=0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic check_cc(input string name, input logic [2:0] e);
    vec_cnt++;
    if (cc !== e) begin
      err_cnt++;
      $display("FAIL %s_cc got=%b expected=%b", name, cc, e);
    end
  endtask

  task automatic model(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [2:0] ccn);
    logic signed [W:0] wide;
    case (fun)
      4'd0:    wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
      4'd1:    wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
      4'd2:    wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
    r = wide[W-1:0];
    ccn = {(r == 0), r[W-1], (fun < 4'd2) ? (wide[W] != wide[W-1]) : 1'b0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vec_cnt++;
    if (bus.out_valid_o !== 1'b0 || bus.valE_o !== '0 || cc !== 3'b100 || busy !== 1'b0 ||
        bad !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset got=v%b e%h cc%b b%b bad%b rdy%b expected=v0 e0 cc100 b0 bad0 rdy1",
               bus.out_valid_o, bus.valE_o, cc, busy, bad, bus.in_ready_o);
    end
    rst = 1'b0;
    exp_cc = 3'b100;
  endtask

  task automatic test_opq();
    int w;
    send(OPQ, 4'd1, 64'd5, 64'd3, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, w);
    check_cc("opq_sub", 3'b010);
    send(OPQ, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFE, w);
    check_cc("opq_add_of", 3'b011);
    send(OPQ, 4'd1, 64'd9, 64'd9, 64'd0, 1'b0, 64'd0, w);
    check_cc("opq_nocc", 3'b011);
    exp_cc = 3'b011;
    wait_drain("opq");
  endtask

  task automatic test_back_to_back();
    int w;
    send(PUSHQ, 4'd0, 64'd0, 64'h100, 64'd0, 1'b1, 64'hF8, w);
    send(POPQ, 4'd0, 64'd0, 64'hF8, 64'd0, 1'b1, 64'h100, w);
    vec_cnt++;
    if (bus.out_valid_o !== 1'b1 || w != 0) begin
      err_cnt++;
      $display("FAIL b2b_stream got=v%b wait%0d expected=v1 wait0", bus.out_valid_o, w);
    end
    check_cc("b2b", exp_cc);
    wait_drain("b2b");
  endtask

  task automatic test_backpressure();
    int w;
    bus.out_ready_i = 1'b0;
    send(IXX, 4'd0, 64'd0, 64'd0, 64'h1234, 1'b1, 64'h1234, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (bus.out_valid_o !== 1'b1 || bus.valE_o !== 64'h1234 || bus.in_ready_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold got=v%b e%h rdy%b expected=v1 e1234 rdy0",
                 bus.out_valid_o, bus.valE_o, bus.in_ready_o);
      end
    end
    tick();
    bus.out_ready_i = 1'b1;
    send(HALT, 4'd0, 64'd1, 64'd2, 64'd3, 1'b1, 64'd0, w);
    vec_cnt++;
    if (w != 0) begin
      err_cnt++;
      $display("FAIL bp_release got=wait%0d expected=wait0", w);
    end
    check_cc("bp", exp_cc);
    wait_drain("bp");
  endtask

  task automatic test_flush();
    int w;
    bus.E_icode_i = OPQ; bus.E_ifun_i = 4'd3; bus.E_valA_i = 64'd7; bus.E_valB_i = 64'd7;
    bus.set_cc_i = 1'b1; bus.in_valid_i = 1'b1; bus.flush_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
    vec_cnt++;
    if (bus.out_valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_drop got=v%b expected=v0", bus.out_valid_o);
    end
    check_cc("flush", exp_cc);
    bus.out_ready_i = 1'b0;
    send(IXX, 4'd0, 64'd0, 64'd0, 64'h55, 1'b1, 64'h55, w);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    void'(exp_q.pop_back());
    vec_cnt++;
    if (bus.out_valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_held got=v%b expected=v0", bus.out_valid_o);
    end
    bus.out_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    int w;
    bus.out_ready_i = 1'b0;
    send(OPQ, 4'd1, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, w);
    rst = 1'b1;
    tick();
    vec_cnt++;
    if (bus.out_valid_o !== 1'b0 || bus.valE_o !== '0 || cc !== 3'b100 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid got=v%b e%h cc%b b%b expected=v0 e0 cc100 b0",
               bus.out_valid_o, bus.valE_o, cc, busy);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_cc = 3'b100;
    bus.out_ready_i = 1'b1;
  endtask

  task automatic test_bad_fun();
    int w;
    send(OPQ, 4'd7, 64'd3, 64'd4, 64'd0, 1'b1, 64'd0, w);
    vec_cnt++;
    if (bad !== 1'b1 || bus.out_valid_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL bad_pulse got=bad%b v%b expected=bad1 v1", bad, bus.out_valid_o);
    end
    tick();
    vec_cnt++;
    if (bad !== 1'b0) begin
      err_cnt++;
      $display("FAIL bad_width got=%b expected=0", bad);
    end
    check_cc("bad", exp_cc);
`ifndef ALU_MUL_EN
    send(OPQ, 4'd4, 64'd3, 64'd5, 64'd0, 1'b1, 64'd0, w);
    vec_cnt++;
    if (bad !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_absent got=bad%b busy%b expected=bad1 busy0", bad, busy);
    end
    check_cc("mul_absent", exp_cc);
`endif
    wait_drain("bad");
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input logic [2:0] ecc);
    int w;
    int n = 0;
    send(OPQ, 4'd4, a, b, 64'd0, 1'b1, exp, w);
    while (busy && n < 100) begin tick(); n++; end
    vec_cnt++;
    if (n != 32 || bus.out_valid_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_busy got=%0d_v%b expected=32_v1", name, n, bus.out_valid_o);
    end
    check_cc(name, ecc);
    exp_cc = ecc;
    wait_drain(name);
  endtask

  task automatic test_mul();
    int w;
    run_mul("mul_neg", -64'sd3, 64'd7, -64'sd21, 3'b010);
    run_mul("mul_of", 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 3'b101);
    send(OPQ, 4'd4, 64'd5, 64'd5, 64'd0, 1'b1, 64'd25, w);
    repeat (5) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    exp_q.delete();
    vec_cnt++;
    if (busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_flush got=busy%b v%b expected=busy0 v0", busy, bus.out_valid_o);
    end
    check_cc("mul_flush", exp_cc);
  endtask
`endif

  task automatic test_random();
    int w;
    logic [3:0] fun;
    logic [W-1:0] a, b, c, r;
    logic [2:0] ccn;
    logic scc, ixx;
    for (int i = 0; i < 24; i++) begin
      fun = 4'($urandom_range(0, 3));
      ixx = 1'($urandom_range(0, 1));
      scc = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
      if (i % 4 == 0) b = a;
      if (ixx) model(fun, b, c, r, ccn);
      else     model(fun, b, a, r, ccn);
      if (ixx) send(IXX, fun + 4'd1, a, b, c, scc, r, w);
      else     send(OPQ, fun, a, b, c, scc, r, w);
      if (scc) exp_cc = ccn;
      check_cc("random", exp_cc);
    end
    wait_drain("random");
  endtask

  initial begin
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1; bus.set_cc_i = 1'b0;
    bus.E_icode_i = NOP; bus.E_ifun_i = 4'd0;
    bus.E_valA_i = '0; bus.E_valB_i = '0; bus.E_valC_i = '0;
    test_reset();
    test_opq();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_bad_fun();
`ifdef ALU_MUL_EN
    test_mul();
`endif
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
